// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared types and constants for the raster tile walker
// Contents: coord_t coordinate type, walker_state_e FSM encoding,
//           default tile size, coordinate width and plane-equation latency.
package raster_pkg;

    localparam int RASTER_COORD_W = 16;
    localparam int TILE_SIZE_DEF  = 2;
    // Fixed latency of the downstream plane-equation evaluator, tile issue to z.
    localparam int PLANE_EQ_LAT   = 20;

    typedef logic [RASTER_COORD_W-1:0] coord_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } walker_state_e;

endpackage

// File: rtl/shift_reg.sv
// rtl/shift_reg.sv - fixed-depth pipeline delay line with clock enable
// Ports: clk, rst (sync active-low), clk_en (advance), din -> dout after DEPTH enabled cycles.
module shift_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else if (clk_en) begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/tile_mask_gen.sv
// rtl/tile_mask_gen.sv - combinational per-pixel bbox coverage for one tile
// Ports: cx, cy (tile origin), xmin/ymin/xmax/ymax (raw inclusive bbox) -> mask,
//        bit i*SIZE+j covers pixel (cx+j, cy+i).
module tile_mask_gen #(
    parameter int SIZE    = 2,
    parameter int COORD_W = 16
) (
    input  logic [COORD_W-1:0]   cx,
    input  logic [COORD_W-1:0]   cy,
    input  logic [COORD_W-1:0]   xmin,
    input  logic [COORD_W-1:0]   ymin,
    input  logic [COORD_W-1:0]   xmax,
    input  logic [COORD_W-1:0]   ymax,
    output logic [SIZE*SIZE-1:0] mask
);

    localparam int W = COORD_W + 1;

    // One extra bit so pixels past the top of the coordinate range never
    // alias back to small values and falsely match the bbox.
    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            logic [W-1:0] px;
            logic [W-1:0] py;
            assign px = {1'b0, cx} + W'(j);
            assign py = {1'b0, cy} + W'(i);
            assign mask[i*SIZE+j] = (px >= {1'b0, xmin}) && (px <= {1'b0, xmax}) &&
                                    (py >= {1'b0, ymin}) && (py <= {1'b0, ymax});
        end
    end

endmodule

// File: rtl/raster_tile_walker.sv
// rtl/raster_tile_walker.sv - walks a bbox in SIZE x SIZE tiles, emits aligned coverage
// Ports: clk, rst (sync active-low); bbox_valid/bbox_ready, xmin/ymin/xmax/ymax in;
//        tile_en throttle; tile_x/tile_y/tile_valid to the plane-equation block;
//        z_valid/z_mask/z_last delayed PIPE_LAT; busy.
// Optional: RASTER_TILE_PERF_EN adds saturating perf_tiles/perf_throttle counters.
module raster_tile_walker
    import raster_pkg::*;
#(
    parameter int SIZE     = TILE_SIZE_DEF,
    parameter int PIPE_LAT = PLANE_EQ_LAT,
    parameter int COORD_W  = RASTER_COORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bbox_valid,
    output logic                 bbox_ready,
    input  logic [COORD_W-1:0]   xmin,
    input  logic [COORD_W-1:0]   ymin,
    input  logic [COORD_W-1:0]   xmax,
    input  logic [COORD_W-1:0]   ymax,
    input  logic                 tile_en,
    output logic [COORD_W-1:0]   tile_x,
    output logic [COORD_W-1:0]   tile_y,
    output logic                 tile_valid,
    output logic                 z_valid,
    output logic [SIZE*SIZE-1:0] z_mask,
    output logic                 z_last,
`ifdef RASTER_TILE_PERF_EN
    output logic [31:0]          perf_tiles,
    output logic [31:0]          perf_throttle,
`endif
    output logic                 busy
);

    localparam int W     = COORD_W + 1;
    localparam int MW    = SIZE * SIZE;
    localparam int CNT_W = $clog2(PIPE_LAT + 1);
    localparam logic [COORD_W-1:0] ALIGN = ~COORD_W'(SIZE - 1);
    localparam logic [W-1:0]       STEP  = W'(SIZE);

    walker_state_e      state;
    logic [COORD_W-1:0] cx, cy;
    logic [COORD_W-1:0] bx0, by0, bx1, by1;
    logic [MW-1:0]      tile_mask;
    logic               tile_last;
    logic [MW-1:0]      cur_mask;
    logic [W-1:0]       cx_sum, cy_sum;
    logic               row_wrap, walk_done;
    logic [CNT_W-1:0]   inflight;

    tile_mask_gen #(.SIZE(SIZE), .COORD_W(COORD_W)) u_mask (
        .cx   (cx),
        .cy   (cy),
        .xmin (bx0),
        .ymin (by0),
        .xmax (bx1),
        .ymax (by1),
        .mask (cur_mask)
    );

    assign cx_sum    = {1'b0, cx} + STEP;
    assign cy_sum    = {1'b0, cy} + STEP;
    assign row_wrap  = cx_sum > {1'b0, bx1};
    assign walk_done = row_wrap && (cy_sum > {1'b0, by1});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bbox_ready <= 1'b0;
            tile_valid <= 1'b0;
            tile_x     <= '0;
            tile_y     <= '0;
            tile_mask  <= '0;
            tile_last  <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            bx0        <= '0;
            by0        <= '0;
            bx1        <= '0;
            by1        <= '0;
        end else begin
            // Mask and last are only meaningful alongside tile_valid; keep them
            // zero otherwise so the delay line carries clean idle slots.
            tile_valid <= 1'b0;
            tile_mask  <= '0;
            tile_last  <= 1'b0;
            case (state)
                IDLE: begin
                    bbox_ready <= 1'b1;
                    if (bbox_valid && bbox_ready) begin
                        bx0 <= xmin;
                        by0 <= ymin;
                        bx1 <= xmax;
                        by1 <= ymax;
                        cx  <= xmin & ALIGN;
                        cy  <= ymin & ALIGN;
                        if (!((xmin > xmax) || (ymin > ymax))) begin
                            state      <= WALK;
                            bbox_ready <= 1'b0;
                        end
                    end
                end
                WALK: begin
                    if (tile_en) begin
                        tile_valid <= 1'b1;
                        tile_x     <= cx;
                        tile_y     <= cy;
                        tile_mask  <= cur_mask;
                        if (row_wrap) begin
                            cx <= bx0 & ALIGN;
                            cy <= cy_sum[COORD_W-1:0];
                            if (walk_done) begin
                                tile_last  <= 1'b1;
                                state      <= IDLE;
                                bbox_ready <= 1'b1;
                            end
                        end else begin
                            cx <= cx_sum[COORD_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The evaluator is free-running, so the coverage pipe never stalls.
    shift_reg #(.WIDTH(MW + 2), .DEPTH(PIPE_LAT)) u_delay (
        .clk    (clk),
        .rst    (rst),
        .clk_en (1'b1),
        .din    ({tile_valid, tile_mask, tile_last}),
        .dout   ({z_valid, z_mask, z_last})
    );

    // Number of valid tiles currently inside the delay line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CNT_W'(tile_valid) - CNT_W'(z_valid);
        end
    end

    assign busy = (state == WALK) || tile_valid || (inflight != '0);

`ifdef RASTER_TILE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_tiles    <= '0;
            perf_throttle <= '0;
        end else if (state == WALK) begin
            if (tile_en && (perf_tiles != 32'hFFFF_FFFF)) begin
                perf_tiles <= perf_tiles + 32'd1;
            end
            if (!tile_en && (perf_throttle != 32'hFFFF_FFFF)) begin
                perf_throttle <= perf_throttle + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_raster_tile_walker.sv
// tb/tb_raster_tile_walker.sv - self-checking bench for raster_tile_walker
module tb_raster_tile_walker;

    localparam int LAT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        bbox_valid;
    logic        bbox_ready;
    logic [15:0] xmin, ymin, xmax, ymax;
    logic        tile_en;
    logic [15:0] tile_x, tile_y;
    logic        tile_valid;
    logic        z_valid;
    logic [3:0]  z_mask;
    logic        z_last;
    logic        busy;
`ifdef RASTER_TILE_PERF_EN
    logic [31:0] perf_tiles, perf_throttle;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    raster_tile_walker dut (
        .clk        (clk),
        .rst        (rst),
        .bbox_valid (bbox_valid),
        .bbox_ready (bbox_ready),
        .xmin       (xmin),
        .ymin       (ymin),
        .xmax       (xmax),
        .ymax       (ymax),
        .tile_en    (tile_en),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .tile_valid (tile_valid),
        .z_valid    (z_valid),
        .z_mask     (z_mask),
        .z_last     (z_last),
`ifdef RASTER_TILE_PERF_EN
        .perf_tiles    (perf_tiles),
        .perf_throttle (perf_throttle),
`endif
        .busy       (busy)
    );

    typedef struct {
        logic [15:0]      x0, y0, x1, y1;
        int               n;
        logic [0:3][15:0] tx;
        logic [0:3][15:0] ty;
        logic [0:3][3:0]  m;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bbox_ready && !busy) && n < 200) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic offer(input logic [15:0] x0, y0, x1, y1);
        xmin = x0; ymin = y0; xmax = x1; ymax = y1;
        bbox_valid = 1'b1;
        step();
        bbox_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        wait_idle();
        offer(v.x0, v.y0, v.x1, v.y1);
        tag = $sformatf("v%0d", idx);
        chk({tag, "_ready_low"}, 32'(bbox_ready), 32'd0);
        for (int k = 0; k < v.n; k++) begin
            step();
            chk($sformatf("%s_t%0d_valid", tag, k), 32'(tile_valid), 32'd1);
            chk($sformatf("%s_t%0d_x", tag, k), 32'(tile_x), 32'(v.tx[k]));
            chk($sformatf("%s_t%0d_y", tag, k), 32'(tile_y), 32'(v.ty[k]));
        end
        chk({tag, "_ready_back"}, 32'(bbox_ready), 32'd1);
        repeat (LAT - v.n) step();
        chk({tag, "_z_early"}, 32'(z_valid), 32'd0);
        for (int k = 0; k < v.n; k++) begin
            step();
            chk($sformatf("%s_z%0d_valid", tag, k), 32'(z_valid), 32'd1);
            chk($sformatf("%s_z%0d_mask", tag, k), 32'(z_mask), 32'(v.m[k]));
            chk($sformatf("%s_z%0d_last", tag, k), 32'(z_last), 32'(k == v.n - 1));
        end
        step();
        chk({tag, "_z_after"}, 32'(z_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{x0:16'd0, y0:16'd0, x1:16'd3, y1:16'd3, n:4,
                    tx:{16'd0, 16'd2, 16'd0, 16'd2}, ty:{16'd0, 16'd0, 16'd2, 16'd2},
                    m:{4'hF, 4'hF, 4'hF, 4'hF}};
        vecs[1] = '{x0:16'd1, y0:16'd1, x1:16'd2, y1:16'd2, n:4,
                    tx:{16'd0, 16'd2, 16'd0, 16'd2}, ty:{16'd0, 16'd0, 16'd2, 16'd2},
                    m:{4'h8, 4'h4, 4'h2, 4'h1}};
        vecs[2] = '{x0:16'd5, y0:16'd7, x1:16'd5, y1:16'd7, n:1,
                    tx:{16'd4, 16'd0, 16'd0, 16'd0}, ty:{16'd6, 16'd0, 16'd0, 16'd0},
                    m:{4'h8, 4'h0, 4'h0, 4'h0}};
        vecs[3] = '{x0:16'd3, y0:16'd0, x1:16'd4, y1:16'd0, n:2,
                    tx:{16'd2, 16'd4, 16'd0, 16'd0}, ty:{16'd0, 16'd0, 16'd0, 16'd0},
                    m:{4'h2, 4'h1, 4'h0, 4'h0}};
        vecs[4] = '{x0:16'hFFFC, y0:16'd0, x1:16'hFFFF, y1:16'd1, n:2,
                    tx:{16'hFFFC, 16'hFFFE, 16'd0, 16'd0}, ty:{16'd0, 16'd0, 16'd0, 16'd0},
                    m:{4'hF, 4'hF, 4'h0, 4'h0}};

        rst = 1'b0;
        bbox_valid = 1'b0;
        xmin = '0; ymin = '0; xmax = '0; ymax = '0;
        tile_en = 1'b1;

        // Reset state
        repeat (2) step();
        chk("rst_ready", 32'(bbox_ready), 32'd0);
        chk("rst_tile_valid", 32'(tile_valid), 32'd0);
        chk("rst_tile_x", 32'(tile_x), 32'd0);
        chk("rst_tile_y", 32'(tile_y), 32'd0);
        chk("rst_z_valid", 32'(z_valid), 32'd0);
        chk("rst_z_mask", 32'(z_mask), 32'd0);
        chk("rst_z_last", 32'(z_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_ready", 32'(bbox_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Degenerate bbox: discarded, nothing issued
        wait_idle();
        offer(16'd8, 16'd0, 16'd4, 16'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("degen_c%0d_tile_valid", k), 32'(tile_valid), 32'd0);
            chk($sformatf("degen_c%0d_ready", k), 32'(bbox_ready), 32'd1);
            chk($sformatf("degen_c%0d_busy", k), 32'(busy), 32'd0);
            step();
        end

        // Throttled walk at the top of the x range
        wait_idle();
        offer(16'hFFFC, 16'd0, 16'hFFFF, 16'd1);
        step();
        chk("thr_t0_valid", 32'(tile_valid), 32'd1);
        chk("thr_t0_x", 32'(tile_x), 32'hFFFC);
        tile_en = 1'b0;
        step();
        chk("thr_hold_valid", 32'(tile_valid), 32'd0);
        chk("thr_hold_busy", 32'(busy), 32'd1);
        chk("thr_hold_ready", 32'(bbox_ready), 32'd0);
        tile_en = 1'b1;
        step();
        chk("thr_t1_valid", 32'(tile_valid), 32'd1);
        chk("thr_t1_x", 32'(tile_x), 32'hFFFE);
        chk("thr_t1_y", 32'(tile_y), 32'd0);
        chk("thr_t1_ready", 32'(bbox_ready), 32'd1);
        step();
        chk("thr_done_valid", 32'(tile_valid), 32'd0);
        repeat (LAT - 3) step();
        chk("thr_z0_valid", 32'(z_valid), 32'd1);
        chk("thr_z0_last", 32'(z_last), 32'd0);
        step();
        chk("thr_zgap_valid", 32'(z_valid), 32'd0);
        step();
        chk("thr_z1_valid", 32'(z_valid), 32'd1);
        chk("thr_z1_last", 32'(z_last), 32'd1);
        chk("thr_z1_mask", 32'(z_mask), 32'hF);

        // Reset in the middle of a large walk
        wait_idle();
        offer(16'd0, 16'd0, 16'd15, 16'd15);
        repeat (5) step();
        chk("mid_walking", 32'(tile_valid), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_tile_valid", 32'(tile_valid), 32'd0);
        chk("mid_rst_z_valid", 32'(z_valid), 32'd0);
        step();
        chk("mid_rst_ready", 32'(bbox_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        begin
            int zseen = 0;
            for (int k = 0; k < LAT + 5; k++) begin
                if (z_valid || z_last || tile_valid) zseen++;
                step();
            end
            chk("mid_rst_no_output", 32'(zseen), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/raster_tile_walker.md
Name: raster_tile_walker

Overview:
Rasterizer stage directly upstream of the plane-equation evaluator. Accepts a screen-space bounding box via a valid/ready handshake. Walks it in row-major order in SIZE x SIZE tiles, issuing one tile origin (x, y) per enabled cycle to the plane-equation block. Generates a per-pixel bbox coverage mask and a last-tile flag, delayed by the evaluator's fixed latency so they arrive aligned with its z outputs.

Parameters:
SIZE, 2, tile edge in pixels; power of two, >= 2; must equal the plane-equation block's SIZE
PIPE_LAT, 20, cycles from tile_x/tile_y issue to the matching z output of the plane-equation block; >= 1
COORD_W, 16, coordinate width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
bbox_valid  in  1  bbox offered
bbox_ready  out  1  walker can accept a bbox
xmin, ymin, xmax, ymax  in  COORD_W each  inclusive bbox, unsigned pixels
tile_en  in  1  downstream throttle; 0 = issue no tile this cycle
tile_x, tile_y  out  COORD_W each  tile origin to the plane-equation block; multiples of SIZE
tile_valid  out  1  tile_x/tile_y carry a real tile this cycle
z_valid  out  1  tile_valid delayed PIPE_LAT cycles
z_mask  out  SIZE*SIZE  coverage delayed PIPE_LAT; bit i*SIZE+j is pixel (x+j, y+i), same indexing as z[i][j]
z_last  out  1  last tile of bbox, delayed PIPE_LAT
busy  out  1  WALK state, or any valid bit in the delay line

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; bbox_ready=0 during reset, 1 on the first cycle after; tile_valid, z_valid, z_last, busy=0; z_mask, tile_x, tile_y=0. Entire delay line cleared. Reset mid-walk abandons the bbox; no partial z_last is emitted.
- States: IDLE, WALK. bbox_ready = (state==IDLE).
- IDLE, bbox_valid&&bbox_ready:
  - Latch raw xmin..ymax.
  - Set cx=xmin & ~(SIZE-1), cy=ymin & ~(SIZE-1).
  - If xmin>xmax or ymin>ymax: degenerate; discard and stay IDLE.
  - Otherwise go to WALK next cycle.
- WALK, tile_en=1:
  - tile_valid=1, tile_x=cx, tile_y=cy (registered outputs).
  - Mask bit i*SIZE+j = (xmin<=cx+j<=xmax) && (ymin<=cy+i<=ymax).
  - Advance: if cx+SIZE>xmax then cx=aligned xmin and cy+=SIZE; else cx+=SIZE.
  - If the row wrapped and cy+SIZE>ymax: last=1, return to IDLE. The next bbox can be accepted the following cycle (one bubble).
- WALK, tile_en=0: tile_valid=0, cx/cy hold, no state change.
- Overflow rule: all cx+SIZE, cy+SIZE, cx+j and cy+i comparisons use COORD_W+1 bits. A bbox touching 0xFFFF terminates correctly with no wrap to 0.
- Tile count = ceil-aligned columns x rows. A 1x1 bbox yields exactly one tile with one mask bit set and last=1.
- Delay line: {tile_valid, mask, last} shifts every cycle unconditionally, PIPE_LAT stages, because the plane-equation block is free-running. Mask and last are zero when tile_valid=0.
- z_* therefore appear exactly PIPE_LAT cycles after the corresponding tile_* cycle.

Optional Feature:
RASTER_TILE_PERF_EN
- Defined: adds outputs perf_tiles (32-bit, increments per issued tile) and perf_throttle (32-bit, increments per WALK cycle with tile_en=0). Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package raster_pkg: coord_t (logic [COORD_W-1:0]), walker_state_e {IDLE, WALK}, default PLANE_EQ_LAT constant used for PIPE_LAT.
- One sub-module: tile_mask_gen. Combinational mask from cx, cy and the raw bbox, parameterised by SIZE.
- Delay line uses the existing shift_reg (WIDTH=2+SIZE*SIZE, DEPTH=PIPE_LAT, clk_en=1).

Test Plan:
- Reset then bbox (0,0)-(3,3), tile_en=1, SIZE=2 -> tiles (0,0),(2,0),(0,2),(2,2) on consecutive cycles, all masks 4'b1111, last on 4th; z_valid pulses exactly 20 cycles later.
- bbox (1,1)-(2,2) -> tiles (0,0) mask 4'b1000, (2,0) mask 4'b0100, (0,2) mask 4'b0010, (2,2) mask 4'b0001 with z_last.
- bbox (5,7)-(5,7) -> single tile (4,6), mask bit 3 only, last=1; bbox_ready back high 2 cycles after acceptance.
- Degenerate bbox (8,0)-(4,0) -> no tile_valid, bbox_ready stays 1, busy stays 0.
- bbox (0xFFFC,0)-(0xFFFF,1) with tile_en toggling 1,0,1 -> tiles (0xFFFC,0),(0xFFFE,0) only, hold during the 0 cycle, terminates (no x wrap).
- rst low for one cycle mid-walk of (0,0)-(15,15) -> next cycle tile_valid=0, all z_valid=0 thereafter, bbox_ready=1.
